// File: rtl/mc_cpu_pkg.sv
// Shared types and encoding constants for the mc_cpu multi-cycle core.
package mc_cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB
   } state_e;

   typedef enum logic [2:0] {
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_ADD,
      ALU_SUB,
      ALU_SLT,
      ALU_SLL
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_SLL = 6'h04;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam int OP_LSB   = 0;
   localparam int RS_LSB   = 6;
   localparam int RT_LSB   = 11;
   localparam int RD_LSB   = 16;
   localparam int IMM_LSB  = 16;
   localparam int FUNC_LSB = 26;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_cpu: result, signed overflow (ADD/SUB only) and zero flag.
module mc_alu
   import mc_cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  alu_op_e           op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] f_o,
   output logic              of_o,
   output logic              zf_o
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   always_comb begin
      f_o  = '0;
      of_o = 1'b0;
      case (op_i)
         ALU_AND: f_o = a_i & b_i;
         ALU_OR:  f_o = a_i | b_i;
         ALU_XOR: f_o = a_i ^ b_i;
         ALU_NOR: f_o = ~(a_i | b_i);
         ALU_ADD: begin
            f_o  = sum;
            of_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
         end
         ALU_SUB: begin
            f_o  = diff;
            of_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
         end
         ALU_SLT: f_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLL: f_o = a_i << b_i[4:0];
         default: f_o = '0;
      endcase
   end

   assign zf_o = (f_o == '0);

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/WB over a req/ack instruction memory.
// Optional BEQ support is enabled by defining MC_CPU_BEQ_EN.
//
// state     | meaning
// ST_IDLE   | waiting for RUN
// ST_FETCH  | IMEM_REQ held until IMEM_ACK, IR captured
// ST_DECODE | operand latch A/B from register file or immediate
// ST_EXEC   | ALU result and flags registered
// ST_WB     | register write, PC advance, RETIRE/ILLEGAL pulse
module mc_cpu
   import mc_cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32,
   parameter int PC_W   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RUN,
   output logic              IMEM_REQ,
   output logic [PC_W-1:0]   IMEM_ADDR,
   input  logic              IMEM_ACK,
   input  logic [31:0]       IMEM_DATA,
   output logic [DATA_W-1:0] ALU_OUT,
   output logic              ALU_OF,
   output logic              ALU_ZF,
   output logic              RETIRE,
   output logic              ILLEGAL
);

   localparam int REG_AW = $clog2(REG_N);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] alu_out_q;
   logic              alu_of_q, alu_zf_q;
   logic [DATA_W-1:0] regs_q [REG_N];

   logic [5:0]        op, func;
   logic [REG_AW-1:0] rs, rt, rd, dest;
   logic [DATA_W-1:0] imm_ext, rs_val, rt_val;
   logic              legal, use_imm, is_beq;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] alu_f;
   logic              alu_of, alu_zf;

   assign op      = ir_q[OP_LSB +: 6];
   assign func    = ir_q[FUNC_LSB +: 6];
   assign rs      = ir_q[RS_LSB +: REG_AW];
   assign rt      = ir_q[RT_LSB +: REG_AW];
   assign rd      = ir_q[RD_LSB +: REG_AW];
   assign imm_ext = DATA_W'($signed(ir_q[IMM_LSB +: 16]));
   assign rs_val  = (rs == '0) ? '0 : regs_q[rs];
   assign rt_val  = (rt == '0) ? '0 : regs_q[rt];

   always_comb begin
      legal   = 1'b0;
      use_imm = 1'b0;
      is_beq  = 1'b0;
      alu_op  = ALU_ADD;
      dest    = rd;
      if (op == OP_RTYPE) begin
         legal = 1'b1;
         case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL:  alu_op = ALU_SLL;
            default: legal  = 1'b0;
         endcase
      end else if (op == OP_ADDI) begin
         legal   = 1'b1;
         use_imm = 1'b1;
         dest    = rt;
`ifdef MC_CPU_BEQ_EN
      end else if (op == OP_BEQ) begin
         legal  = 1'b1;
         is_beq = 1'b1;
         alu_op = ALU_SUB;
`endif
      end
   end

   mc_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i (alu_op),
      .a_i  (a_q),
      .b_i  (b_q),
      .f_o  (alu_f),
      .of_o (alu_of),
      .zf_o (alu_zf)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (RUN) state_d = ST_FETCH;
         ST_FETCH:  if (IMEM_ACK) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WB;
         ST_WB:     state_d = RUN ? ST_FETCH : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Branch taken uses the zero flag registered in EXEC from A-B.
   always_comb begin
      pc_d = pc_q + PC_W'(4);
      if (is_beq && alu_zf_q)
         pc_d = pc_q + PC_W'(4) + PC_W'($signed({ir_q[IMM_LSB +: 16], 2'b00}));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         alu_of_q  <= 1'b0;
         alu_zf_q  <= 1'b1;
         for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_FETCH: if (IMEM_ACK) ir_q <= IMEM_DATA;
            ST_DECODE: begin
               a_q <= rs_val;
               b_q <= use_imm ? imm_ext : rt_val;
            end
            ST_EXEC: if (legal) begin
               alu_out_q <= alu_f;
               alu_of_q  <= is_beq ? 1'b0 : alu_of;
               alu_zf_q  <= alu_zf;
            end
            ST_WB: begin
               pc_q <= pc_d;
               if (legal && !is_beq && (dest != '0)) regs_q[dest] <= alu_out_q;
            end
            default: ;
         endcase
      end
   end

   assign IMEM_REQ  = (state_q == ST_FETCH);
   assign IMEM_ADDR = pc_q;
   assign ALU_OUT   = alu_out_q;
   assign ALU_OF    = alu_of_q;
   assign ALU_ZF    = alu_zf_q;
   assign RETIRE    = (state_q == ST_WB);
   assign ILLEGAL   = (state_q == ST_WB) && !legal;

endmodule
